ulpi_bus_ctrl: RTL and testbench

- Link-side controller for the USB3300 ULPI 8-bit bidirectional data bus.
- Sequences ULPI register write and read transactions: TXCMD, data phase, STP.
- Honours PHY bus ownership (DIR), turnaround cycles and NXT throttling; retries on DIR preemption; captures RX CMD bytes while the PHY owns the bus.
- The pad tri-state lives in the top level, driven by ulpi_data_out/ulpi_data_oe; this block contains no inout.

---
 rtl/ulpi_bus_ctrl.sv | 153 +++++++++++++++
 tb/tb_ulpi_bus_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ulpi_bus_ctrl.sv
// rtl/ulpi_bus_ctrl.sv - ULPI link-side register access sequencer (TXCMD, data, STP, turnaround, retry)
module ulpi_bus_ctrl #(
  parameter int MAX_RETRY   = 3,
  parameter int NXT_TIMEOUT = 255
) (
  input  logic       clk_ice,
  input  logic       rstn,
  input  logic       ulpi_dir,
  input  logic       ulpi_nxt,
  input  logic [7:0] ulpi_data_in,
  output logic [7:0] ulpi_data_out,
  output logic       ulpi_data_oe,
  output logic       ulpi_stp,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [5:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_error,
  output logic       rxcmd_valid,
  output logic [7:0] rxcmd_data
);

  typedef enum logic [3:0] {
    S_IDLE, S_TXCMD, S_WDATA, S_STP, S_RD_TURN, S_RD_DATA, S_RD_END, S_ABORT, S_RESP
  } state_t;

  localparam logic [7:0]  LP_MAX_RETRY = 8'(MAX_RETRY);
  localparam logic [15:0] LP_TMO_LAST  = 16'(NXT_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_dir_q;
  logic        r_live;
  logic        r_write;
  logic [5:0]  r_addr;
  logic [7:0]  r_wdata;
  logic [7:0]  r_rdata;
  logic [7:0]  r_retry;
  logic [15:0] r_tmo;
  logic        r_err;

  logic w_bus_free;
  logic w_accept;
  logic w_rx_sample;
  logic w_link_phase;
  logic w_tmo_hit;
  logic w_set_err;
  logic w_cap;
  logic w_retry_inc;

  assign w_bus_free   = !ulpi_dir && !r_dir_q;
  assign w_accept     = req_valid && req_ready;
  assign w_rx_sample  = r_dir_q && ulpi_dir && !ulpi_nxt;
  assign w_link_phase = (r_state == S_TXCMD) || (r_state == S_WDATA);
  assign w_tmo_hit    = w_link_phase && !ulpi_nxt && (r_tmo == LP_TMO_LAST);

  always_comb begin
    w_next      = r_state;
    w_set_err   = 1'b0;
    w_cap       = 1'b0;
    w_retry_inc = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_TXCMD;
      // dir wins over a coincident nxt: the PHY has taken the bus back
      S_TXCMD: begin
        if (ulpi_dir)       w_next = S_ABORT;
        else if (ulpi_nxt)  w_next = r_write ? S_WDATA : S_RD_TURN;
        else if (w_tmo_hit) begin w_next = S_RESP; w_set_err = 1'b1; end
      end
      S_WDATA: begin
        if (ulpi_dir)       w_next = S_ABORT;
        else if (ulpi_nxt)  w_next = S_STP;
        else if (w_tmo_hit) begin w_next = S_RESP; w_set_err = 1'b1; end
      end
      S_STP:     w_next = S_RESP;
      S_RD_TURN: if (ulpi_dir) w_next = S_RD_DATA;
      S_RD_DATA: begin
        if (ulpi_nxt || !ulpi_dir) w_next = S_ABORT;
        else if (r_dir_q) begin w_cap = 1'b1; w_next = S_RD_END; end
      end
      S_RD_END:  if (!ulpi_dir) w_next = S_RESP;
      // exit on the dir-low turnaround cycle so TXCMD is driven the cycle after
      S_ABORT: begin
        if (!ulpi_dir) begin
          if (r_retry < LP_MAX_RETRY) begin
            w_next      = S_TXCMD;
            w_retry_inc = 1'b1;
          end else begin
            w_next    = S_RESP;
            w_set_err = 1'b1;
          end
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_ice or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_dir_q <= 1'b0;
      r_live  <= 1'b0;
      r_write <= 1'b0;
      r_addr  <= 6'd0;
      r_wdata <= 8'd0;
      r_rdata <= 8'd0;
      r_retry <= 8'd0;
      r_tmo   <= 16'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_dir_q <= ulpi_dir;
      r_live  <= 1'b1;
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_rdata <= 8'd0;
        r_retry <= 8'd0;
        r_err   <= 1'b0;
      end
      if (w_cap)       r_rdata <= ulpi_data_in;
      if (w_retry_inc) r_retry <= r_retry + 8'd1;
      if (w_set_err)   r_err   <= 1'b1;
      if (w_next != r_state)             r_tmo <= 16'd0;
      else if (w_link_phase && !ulpi_nxt) r_tmo <= r_tmo + 16'd1;
    end
  end

  always_comb begin
    ulpi_data_out = 8'd0;
    case (r_state)
      S_TXCMD: ulpi_data_out = {1'b1, !r_write, r_addr};
      S_WDATA: ulpi_data_out = r_wdata;
      default: ulpi_data_out = 8'd0;
    endcase
  end

  // r_live keeps req_ready low while reset is held and for the first cycle after
  assign req_ready    = (r_state == S_IDLE) && w_bus_free && r_live;
  assign ulpi_data_oe = ((r_state == S_TXCMD) || (r_state == S_WDATA) || (r_state == S_STP)) && w_bus_free;
  assign ulpi_stp     = (r_state == S_STP);
  assign rsp_valid    = (r_state == S_RESP);
  assign rsp_error    = (r_state == S_RESP) && r_err;
  assign rsp_rdata    = r_rdata;
  assign rxcmd_valid  = w_rx_sample && (r_state != S_RD_DATA);
  assign rxcmd_data   = rxcmd_valid ? ulpi_data_in : 8'd0;

endmodule

// File: tb/tb_ulpi_bus_ctrl.sv
// tb/tb_ulpi_bus_ctrl.sv - randomized PHY-script bench for ulpi_bus_ctrl with transaction-level expectations
module tb_ulpi_bus_ctrl;

  localparam int MAX_RETRY   = 3;
  localparam int NXT_TIMEOUT = 255;

  logic       clk_ice = 1'b0;
  logic       rstn = 1'b0;
  logic       ulpi_dir = 1'b0;
  logic       ulpi_nxt = 1'b0;
  logic [7:0] ulpi_data_in = 8'd0;
  logic [7:0] ulpi_data_out;
  logic       ulpi_data_oe;
  logic       ulpi_stp;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [5:0] req_addr = 6'd0;
  logic [7:0] req_wdata = 8'd0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_error;
  logic       rxcmd_valid;
  logic [7:0] rxcmd_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_ice = ~clk_ice;

  ulpi_bus_ctrl #(.MAX_RETRY(MAX_RETRY), .NXT_TIMEOUT(NXT_TIMEOUT)) u_dut (
    .clk_ice(clk_ice), .rstn(rstn),
    .ulpi_dir(ulpi_dir), .ulpi_nxt(ulpi_nxt), .ulpi_data_in(ulpi_data_in),
    .ulpi_data_out(ulpi_data_out), .ulpi_data_oe(ulpi_data_oe), .ulpi_stp(ulpi_stp),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .rxcmd_valid(rxcmd_valid), .rxcmd_data(rxcmd_data)
  );

  // observed traffic, sampled mid-cycle
  int         cyc = 0;
  int         rsp_cyc = -1;
  int         n_stp = 0;
  int         n_oe_bad = 0;
  int         n_rdy_bad = 0;
  logic       prev_dir = 1'b0;
  logic [8:0] q_tx[$];
  logic [8:0] q_rsp[$];
  logic [7:0] q_rx[$];

  // expected traffic
  logic [8:0] e_tx[$];
  logic [7:0] e_rx[$];
  logic [7:0] pre_bytes[$];

  always @(negedge clk_ice) begin
    if (!rstn) begin
      prev_dir <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (ulpi_data_oe) q_tx.push_back({ulpi_stp, ulpi_data_out});
      if (ulpi_stp) n_stp <= n_stp + 1;
      if (ulpi_data_oe && (ulpi_dir || prev_dir)) n_oe_bad <= n_oe_bad + 1;
      if (req_ready && (ulpi_dir || prev_dir)) n_rdy_bad <= n_rdy_bad + 1;
      if (rsp_valid) begin
        q_rsp.push_back({rsp_error, rsp_rdata});
        rsp_cyc <= cyc + 1;
      end
      if (rxcmd_valid) q_rx.push_back(rxcmd_data);
      prev_dir <= ulpi_dir;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_cycle(input logic d, input logic n, input logic [7:0] din);
    ulpi_dir = d;
    ulpi_nxt = n;
    ulpi_data_in = din;
    @(posedge clk_ice);
    #1;
  endtask

  task automatic phy_hold(input int h);
    logic       n;
    logic [7:0] b;
    repeat (h) begin
      n = 1'($urandom_range(0, 1));
      b = 8'($urandom);
      if (!n) e_rx.push_back(b);
      bus_cycle(1'b1, n, b);
    end
  endtask

  task automatic clear_logs();
    q_tx.delete(); q_rx.delete(); q_rsp.delete();
    e_tx.delete(); e_rx.delete();
  endtask

  task automatic do_txn(input logic wr, input logic [5:0] addr, input logic [7:0] wd,
                        input logic [7:0] rd, input int d1, input int d2,
                        input int n_abort, input bit tmo);
    logic [7:0] cmd;
    bit         err;
    int         t_att;
    int         t_resp;
    int         s_stp;
    cmd   = {1'b1, !wr, addr};
    err   = tmo || (n_abort > MAX_RETRY);
    s_stp = n_stp;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    if (pre_bytes.size() > 0) begin
      bus_cycle(1'b1, 1'b0, 8'h00);
      foreach (pre_bytes[i]) begin
        e_rx.push_back(pre_bytes[i]);
        bus_cycle(1'b1, 1'b0, pre_bytes[i]);
      end
      pre_bytes.delete();
      bus_cycle(1'b0, 1'b0, 8'h00);
    end
    bus_cycle(1'b0, 1'b0, 8'h00);
    req_valid = 1'b0;
    for (int i = 0; i < n_abort; i++) begin
      repeat ($urandom_range(0, 3)) begin
        e_tx.push_back({1'b0, cmd});
        bus_cycle(1'b0, 1'b0, 8'($urandom));
      end
      bus_cycle(1'b1, 1'($urandom_range(0, 1)), 8'($urandom));
      phy_hold($urandom_range(0, 3));
      bus_cycle(1'b0, 1'b0, 8'h00);
    end
    t_att = cyc + 1;
    if (n_abort > MAX_RETRY) begin
      t_att = -1;
    end else if (tmo) begin
      repeat (NXT_TIMEOUT) begin
        e_tx.push_back({1'b0, cmd});
        bus_cycle(1'b0, 1'b0, 8'h00);
      end
    end else begin
      repeat (d1) begin
        e_tx.push_back({1'b0, cmd});
        bus_cycle(1'b0, 1'b0, 8'h00);
      end
      e_tx.push_back({1'b0, cmd});
      bus_cycle(1'b0, 1'b1, 8'h00);
      if (wr) begin
        repeat (d2) begin
          e_tx.push_back({1'b0, wd});
          bus_cycle(1'b0, 1'b0, 8'h00);
        end
        e_tx.push_back({1'b0, wd});
        bus_cycle(1'b0, 1'b1, 8'h00);
        e_tx.push_back({1'b1, 8'h00});
        bus_cycle(1'b0, 1'b0, 8'h00);
      end else begin
        repeat (d2) bus_cycle(1'b0, 1'b0, 8'h00);
        bus_cycle(1'b1, 1'b0, 8'h00);
        bus_cycle(1'b1, 1'b0, rd);
        phy_hold($urandom_range(0, 2));
        bus_cycle(1'b0, 1'b0, 8'h00);
      end
    end
    bus_cycle(1'b0, 1'b0, 8'h00);
    t_resp = cyc;
    bus_cycle(1'b0, 1'b0, 8'h00);

    check_eq("rsp_count", q_rsp.size(), 1);
    if (q_rsp.size() > 0)
      check_eq("rsp_err_rdata", q_rsp[0], {23'd0, err, ((wr || err) ? 8'h00 : rd)});
    check_eq("rsp_cycle", rsp_cyc, tmo ? t_att + NXT_TIMEOUT : t_resp);
    check_eq("stp_count", n_stp - s_stp, (wr && !err) ? 1 : 0);
    check_eq("tx_len", q_tx.size(), e_tx.size());
    for (int i = 0; i < e_tx.size() && i < q_tx.size(); i++)
      check_eq("tx_byte", q_tx[i], e_tx[i]);
    check_eq("rx_len", q_rx.size(), e_rx.size());
    for (int i = 0; i < e_rx.size() && i < q_rx.size(); i++)
      check_eq("rxcmd_byte", q_rx[i], e_rx[i]);
    check_eq("oe_while_phy_owns", n_oe_bad, 0);
    check_eq("ready_while_phy_owns", n_rdy_bad, 0);
    clear_logs();
  endtask

  int na;
  bit tm;

  initial begin
    repeat (3) @(posedge clk_ice);
    #1;
    check_eq("rst_oe", ulpi_data_oe, 0);
    check_eq("rst_stp", ulpi_stp, 0);
    check_eq("rst_data_out", ulpi_data_out, 0);
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_error", rsp_error, 0);
    check_eq("rst_rsp_rdata", rsp_rdata, 0);
    check_eq("rst_rxcmd_valid", rxcmd_valid, 0);
    check_eq("rst_rxcmd_data", rxcmd_data, 0);
    rstn = 1'b1;
    repeat (3) bus_cycle(1'b0, 1'b0, 8'h00);

    do_txn(1'b1, 6'h0A, 8'h45, 8'h00, 1, 0, 0, 1'b0);
    do_txn(1'b0, 6'h16, 8'h00, 8'h5C, 0, 0, 0, 1'b0);
    do_txn(1'b1, 6'h0A, 8'h45, 8'h00, 0, 1, 1, 1'b0);
    do_txn(1'b1, 6'h0A, 8'h45, 8'h00, 0, 0, MAX_RETRY + 1, 1'b0);
    do_txn(1'b1, 6'h0A, 8'h45, 8'h00, 0, 0, 0, 1'b1);
    pre_bytes.push_back(8'h4E);
    pre_bytes.push_back(8'h4F);
    do_txn(1'b1, 6'h03, 8'hA5, 8'h00, 0, 0, 0, 1'b0);
    do_txn(1'b0, 6'h3F, 8'h00, 8'hC3, 2, 2, MAX_RETRY, 1'b0);

    for (int k = 0; k < 40; k++) begin
      na = ($urandom_range(0, 7) == 0) ? MAX_RETRY + 1 : int'($urandom_range(0, 2));
      tm = (na == 0) && ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 2) == 0)
        repeat ($urandom_range(1, 3)) pre_bytes.push_back(8'($urandom));
      do_txn(1'($urandom_range(0, 1)), 6'($urandom), 8'($urandom), 8'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3), na, tm);
    end

    req_valid = 1'b1; req_write = 1'b1; req_addr = 6'h21; req_wdata = 8'h99;
    bus_cycle(1'b0, 1'b0, 8'h00);
    req_valid = 1'b0;
    bus_cycle(1'b0, 1'b1, 8'h00);
    bus_cycle(1'b0, 1'b1, 8'h00);
    check_eq("mid_stp_before_reset", ulpi_stp, 1);
    check_eq("mid_oe_before_reset", ulpi_data_oe, 1);
    rstn = 1'b0;
    #1;
    check_eq("mid_oe_after_reset", ulpi_data_oe, 0);
    check_eq("mid_stp_after_reset", ulpi_stp, 0);
    check_eq("mid_rsp_after_reset", rsp_valid, 0);
    bus_cycle(1'b0, 1'b0, 8'h00);
    rstn = 1'b1;
    repeat (2) bus_cycle(1'b0, 1'b0, 8'h00);
    clear_logs();
    do_txn(1'b1, 6'h21, 8'h99, 8'h00, 0, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
